// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and bus widths for the program/data RAM port arbiter.
package ram_port_arbiter_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;

  // Arbiter ownership state; the encoding is exported unchanged on the owner debug output.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CPU_OWN = 2'd1,
    LD_OWN  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Bundle of the CPU port, loader port and RAM-side signals around the arbiter.
// The slave view belongs to the arbiter; the master view is the environment
// (CPU, loader and RAM together).
interface ram_port_arbiter_if;
  import ram_port_arbiter_pkg::*;

  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_w_en;
  logic [DATA_W-1:0] cpu_w_data;
  logic              cpu_gnt;

  logic              ld_req;
  logic [ADDR_W-1:0] ld_addr;
  logic              ld_w_en;
  logic [DATA_W-1:0] ld_w_data;
  logic              ld_lock;
  logic              ld_gnt;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_w_en;
  logic [DATA_W-1:0] ram_w_data;
  logic [DATA_W-1:0] ram_r_data;

  logic [DATA_W-1:0] r_data;
  logic              cpu_r_valid;
  logic              ld_r_valid;
  logic [1:0]        owner;

  modport slave (
    input  cpu_req, cpu_addr, cpu_w_en, cpu_w_data,
    input  ld_req, ld_addr, ld_w_en, ld_w_data, ld_lock,
    input  ram_r_data,
    output cpu_gnt, ld_gnt,
    output ram_addr, ram_w_en, ram_w_data,
    output r_data, cpu_r_valid, ld_r_valid, owner
  );

  modport master (
    output cpu_req, cpu_addr, cpu_w_en, cpu_w_data,
    output ld_req, ld_addr, ld_w_en, ld_w_data, ld_lock,
    output ram_r_data,
    input  cpu_gnt, ld_gnt,
    input  ram_addr, ram_w_en, ram_w_data,
    input  r_data, cpu_r_valid, ld_r_valid, owner
  );

endinterface

// File: rtl/ram_port_arbiter_rsp_pipe.sv
// One-cycle read tag: remembers which port was granted a read so that the RAM
// data returning next cycle can be flagged as belonging to that port.
module ram_port_arbiter_rsp_pipe (
  input  logic clk,
  input  logic rst_n,
  input  logic cpu_rd_i,
  input  logic ld_rd_i,
  output logic cpu_r_valid_o,
  output logic ld_r_valid_o
);

  logic cpu_rd_q;
  logic ld_rd_q;

  // Capture this cycle's granted reads; reset drops any read in flight.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      cpu_rd_q <= 1'b0;
      ld_rd_q  <= 1'b0;
    end else begin
      cpu_rd_q <= cpu_rd_i;
      ld_rd_q  <= ld_rd_i;
    end
  end

  // A read granted just before reset must not report data during the reset cycle.
  assign cpu_r_valid_o = cpu_rd_q & ~rst_n;
  assign ld_r_valid_o  = ld_rd_q & ~rst_n;

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port RAM between the CPU and the loader/debug port.
// CPU has priority; the loader gets burst ownership, a starvation escape and a lock.
// Note: rst_n is active-high (1 = reset) despite its name.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int LD_MAX_BURST = 4,
  parameter int STARVE_LIMIT = 8
) (
  input logic           clk,
  input logic           rst_n,
  ram_port_arbiter_if.slave bus
);

  localparam int BURST_W = $clog2(LD_MAX_BURST + 1);
  localparam int WAIT_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(LD_MAX_BURST);
  localparam logic [BURST_W-1:0] BURST_ONE = BURST_W'(1);
  localparam logic [WAIT_W-1:0]  WAIT_MAX  = WAIT_W'(STARVE_LIMIT);
  localparam logic [WAIT_W-1:0]  WAIT_ONE  = WAIT_W'(1);

  arb_state_t         state_q, state_d;
  logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;

  logic cpu_gnt;
  logic ld_gnt;
  logic ld_locked;
  logic ld_wins;
  logic cpu_rd_valid;
  logic ld_rd_valid;

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q     <= IDLE;
      burst_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  // Next ownership and counters follow whichever port actually got the RAM.
  always_comb begin
    if (cpu_gnt) begin
      state_d = CPU_OWN;
    end else if (ld_gnt || ld_locked) begin
      state_d = LD_OWN;
    end else begin
      state_d = IDLE;
    end

    burst_cnt_d = burst_cnt_q;
    if (ld_gnt) begin
      if (state_q != LD_OWN) begin
        burst_cnt_d = BURST_ONE;
      end else if (burst_cnt_q != BURST_MAX) begin
        burst_cnt_d = burst_cnt_q + BURST_ONE;
      end
    end else if (cpu_gnt || state_d == IDLE) begin
      burst_cnt_d = '0;
    end

    wait_cnt_d = wait_cnt_q;
    if (ld_gnt || !bus.ld_req) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != WAIT_MAX) begin
      wait_cnt_d = wait_cnt_q + WAIT_ONE;
    end
  end

  // Grant decision and RAM mux; a locked loader owns even the slots it leaves empty.
  always_comb begin
    cpu_gnt   = 1'b0;
    ld_gnt    = 1'b0;
    ld_locked = (state_q == LD_OWN) && bus.ld_lock;
    ld_wins   = ((state_q == LD_OWN) && (burst_cnt_q < BURST_MAX)) ||
                (wait_cnt_q == WAIT_MAX);
    if (!rst_n) begin
      if (ld_locked) begin
        ld_gnt = bus.ld_req;
      end else if (bus.cpu_req && bus.ld_req) begin
        ld_gnt  = ld_wins;
        cpu_gnt = !ld_wins;
      end else begin
        cpu_gnt = bus.cpu_req;
        ld_gnt  = bus.ld_req;
      end
    end

    bus.ram_addr   = bus.cpu_addr;
    bus.ram_w_en   = 1'b0;
    bus.ram_w_data = bus.cpu_w_data;
    if (ld_gnt) begin
      bus.ram_addr   = bus.ld_addr;
      bus.ram_w_en   = bus.ld_w_en;
      bus.ram_w_data = bus.ld_w_data;
    end else if (cpu_gnt) begin
      bus.ram_w_en   = bus.cpu_w_en;
    end
  end

  assign cpu_rd_valid = cpu_gnt & ~bus.cpu_w_en;
  assign ld_rd_valid  = ld_gnt & ~bus.ld_w_en;

  ram_port_arbiter_rsp_pipe u_rsp_pipe (
    .clk           (clk),
    .rst_n         (rst_n),
    .cpu_rd_i      (cpu_rd_valid),
    .ld_rd_i       (ld_rd_valid),
    .cpu_r_valid_o (bus.cpu_r_valid),
    .ld_r_valid_o  (bus.ld_r_valid)
  );

  assign bus.cpu_gnt = cpu_gnt;
  assign bus.ld_gnt  = ld_gnt;
  assign bus.r_data  = bus.ram_r_data;
  assign bus.owner   = state_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for the RAM port arbiter with a small behavioural RAM attached.
module tb_ram_port_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [15:0] mem [256];

  ram_port_arbiter_if bus ();

  ram_port_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port RAM: read-first, data one cycle after the address.
  always @(posedge clk) begin
    if (bus.ram_w_en) mem[bus.ram_addr] <= bus.ram_w_data;
    bus.ram_r_data <= mem[bus.ram_addr];
  end

  // Advance one cycle, then drive the next cycle's inputs well after the edge.
  task automatic applyStimulus(input logic rst, input logic cpuReq, input logic [7:0] cpuAddr,
                               input logic cpuWEn, input logic [15:0] cpuWData,
                               input logic ldReq, input logic [7:0] ldAddr, input logic ldWEn,
                               input logic [15:0] ldWData, input logic ldLock);
    @(posedge clk);
    #1;
    rst_n          = rst;
    bus.cpu_req    = cpuReq;
    bus.cpu_addr   = cpuAddr;
    bus.cpu_w_en   = cpuWEn;
    bus.cpu_w_data = cpuWData;
    bus.ld_req     = ldReq;
    bus.ld_addr    = ldAddr;
    bus.ld_w_en    = ldWEn;
    bus.ld_w_data  = ldWData;
    bus.ld_lock    = ldLock;
    #1;
  endtask

  // One comparison with failure accounting.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b1;
    bus.cpu_req = 1'b0; bus.cpu_addr = '0; bus.cpu_w_en = 1'b0; bus.cpu_w_data = '0;
    bus.ld_req = 1'b0; bus.ld_addr = '0; bus.ld_w_en = 1'b0; bus.ld_w_data = '0;
    bus.ld_lock = 1'b0;

    // Reset held with both ports requesting
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 8'h01, 1'b1, 16'hAAAA, 1'b1, 8'h02, 1'b1, 16'h5555, 1'b0);
      checkOutput("rst_cpu_gnt", bus.cpu_gnt, 0);
      checkOutput("rst_ld_gnt", bus.ld_gnt, 0);
      checkOutput("rst_ram_w_en", bus.ram_w_en, 0);
      checkOutput("rst_owner", bus.owner, 0);
      checkOutput("rst_cpu_r_valid", bus.cpu_r_valid, 0);
      checkOutput("rst_ld_r_valid", bus.ld_r_valid, 0);
    end
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 16'h0, 1'b0, 8'h00, 1'b0, 16'h0, 1'b0);
    checkOutput("idle_owner", bus.owner, 0);
    checkOutput("idle_cpu_gnt", bus.cpu_gnt, 0);

    // CPU write then read of 0x10
    applyStimulus(1'b0, 1'b1, 8'h10, 1'b1, 16'hBEEF, 1'b0, 8'h00, 1'b0, 16'h0, 1'b0);
    checkOutput("cpu_wr_gnt", bus.cpu_gnt, 1);
    checkOutput("cpu_wr_ram_w_en", bus.ram_w_en, 1);
    checkOutput("cpu_wr_ram_addr", bus.ram_addr, 8'h10);
    applyStimulus(1'b0, 1'b1, 8'h10, 1'b0, 16'h0, 1'b0, 8'h00, 1'b0, 16'h0, 1'b0);
    checkOutput("cpu_rd_gnt", bus.cpu_gnt, 1);
    checkOutput("cpu_rd_ram_addr", bus.ram_addr, 8'h10);
    checkOutput("cpu_rd_ram_w_en", bus.ram_w_en, 0);
    checkOutput("cpu_wr_no_valid", bus.cpu_r_valid, 0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 16'h0, 1'b0, 8'h00, 1'b0, 16'h0, 1'b0);
    checkOutput("cpu_rd_valid", bus.cpu_r_valid, 1);
    checkOutput("cpu_rd_data", bus.r_data, 16'hBEEF);
    checkOutput("cpu_rd_ld_valid", bus.ld_r_valid, 0);
    checkOutput("cpu_rd_owner", bus.owner, 1);

    // Loader burst: two solo writes, then CPU joins
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 16'h0, 1'b1, 8'h20, 1'b1, 16'h1111, 1'b0);
    checkOutput("burst1_ld_gnt", bus.ld_gnt, 1);
    checkOutput("burst1_owner", bus.owner, 0);
    checkOutput("burst1_ram_addr", bus.ram_addr, 8'h20);
    checkOutput("burst1_ram_w_data", bus.ram_w_data, 16'h1111);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 16'h0, 1'b1, 8'h21, 1'b1, 16'h2222, 1'b0);
    checkOutput("burst2_ld_gnt", bus.ld_gnt, 1);
    checkOutput("burst2_owner", bus.owner, 2);
    applyStimulus(1'b0, 1'b1, 8'h10, 1'b0, 16'h0, 1'b1, 8'h22, 1'b1, 16'h3333, 1'b0);
    checkOutput("burst3_ld_gnt", bus.ld_gnt, 1);
    checkOutput("burst3_cpu_gnt", bus.cpu_gnt, 0);
    applyStimulus(1'b0, 1'b1, 8'h10, 1'b0, 16'h0, 1'b1, 8'h23, 1'b1, 16'h4444, 1'b0);
    checkOutput("burst4_ld_gnt", bus.ld_gnt, 1);
    for (int i = 0; i <= 8; i++) begin
      applyStimulus(1'b0, 1'b1, 8'h10, 1'b0, 16'h0, 1'b1, 8'h24, 1'b1, 16'h5555, 1'b0);
      checkOutput($sformatf("post_burst_cpu_gnt_%0d", i), bus.cpu_gnt, (i < 8) ? 1 : 0);
      checkOutput($sformatf("post_burst_ld_gnt_%0d", i), bus.ld_gnt, (i == 8) ? 1 : 0);
    end

    // No request: RAM sees the CPU address and write data, never a write
    applyStimulus(1'b0, 1'b0, 8'h55, 1'b1, 16'h1234, 1'b0, 8'h66, 1'b1, 16'h9999, 1'b0);
    checkOutput("nognt_ram_addr", bus.ram_addr, 8'h55);
    checkOutput("nognt_ram_w_data", bus.ram_w_data, 16'h1234);
    checkOutput("nognt_ram_w_en", bus.ram_w_en, 0);
    checkOutput("nognt_gnts", {bus.cpu_gnt, bus.ld_gnt}, 0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 16'h0, 1'b0, 8'h00, 1'b0, 16'h0, 1'b0);

    // Starvation: both reading continuously from an idle arbiter
    for (int i = 0; i <= 12; i++) begin
      applyStimulus(1'b0, 1'b1, 8'h10, 1'b0, 16'h0, 1'b1, 8'h20, 1'b0, 16'h0, 1'b0);
      checkOutput($sformatf("starve_cpu_gnt_%0d", i), bus.cpu_gnt, (i < 8 || i == 12) ? 1 : 0);
      checkOutput($sformatf("starve_ld_gnt_%0d", i), bus.ld_gnt, (i >= 8 && i <= 11) ? 1 : 0);
      checkOutput($sformatf("starve_owner_%0d", i), bus.owner, (i == 0) ? 0 : ((i <= 8) ? 1 : 2));
      checkOutput($sformatf("starve_cpu_r_valid_%0d", i), bus.cpu_r_valid, (i >= 1 && i <= 8) ? 1 : 0);
      checkOutput($sformatf("starve_ld_r_valid_%0d", i), bus.ld_r_valid, (i >= 9) ? 1 : 0);
    end
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 16'h0, 1'b0, 8'h00, 1'b0, 16'h0, 1'b0);
    checkOutput("starve_last_cpu_r_valid", bus.cpu_r_valid, 1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 16'h0, 1'b0, 8'h00, 1'b0, 16'h0, 1'b0);

    // Lock: loader enters ownership, then toggles its request with CPU waiting
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 16'h0, 1'b1, 8'h30, 1'b1, 16'h7777, 1'b1);
    checkOutput("lock_enter_ld_gnt", bus.ld_gnt, 1);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b1, 8'h10, 1'b0, 16'h0, (i % 2 == 0), 8'h31, 1'b1, 16'h8888, 1'b1);
      checkOutput($sformatf("lock_cpu_gnt_%0d", i), bus.cpu_gnt, 0);
      checkOutput($sformatf("lock_ld_gnt_%0d", i), bus.ld_gnt, (i % 2 == 0) ? 1 : 0);
      checkOutput($sformatf("lock_owner_%0d", i), bus.owner, 2);
    end
    applyStimulus(1'b0, 1'b1, 8'h10, 1'b0, 16'h0, 1'b1, 8'h32, 1'b1, 16'h9999, 1'b0);
    checkOutput("unlock_cpu_gnt", bus.cpu_gnt, 1);
    checkOutput("unlock_ld_gnt", bus.ld_gnt, 0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 16'h0, 1'b0, 8'h00, 1'b0, 16'h0, 1'b0);

    // Reset arriving right after a loader read
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 16'h0, 1'b1, 8'h20, 1'b0, 16'h0, 1'b0);
    checkOutput("rstrd_ld_gnt", bus.ld_gnt, 1);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 16'h0, 1'b1, 8'h20, 1'b0, 16'h0, 1'b0);
    checkOutput("rstrd_ld_r_valid", bus.ld_r_valid, 0);
    checkOutput("rstrd_ld_gnt_in_rst", bus.ld_gnt, 0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 16'h0, 1'b0, 8'h00, 1'b0, 16'h0, 1'b0);
    checkOutput("rstrd_owner", bus.owner, 0);
    checkOutput("rstrd_ld_r_valid_after", bus.ld_r_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
